// File: rtl/cgia_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cgia_pkg
// Description : Shared constants and state encoding for the CGIA video
//               fetcher (Wishbone read master feeding ping-pong line buffers).
// Revision    : 1.0 - initial release
// ============================================================================
package cgia_pkg;

    // Wishbone word-address width and video data width
    localparam int c_adr_w = 23;
    localparam int c_dat_w = 16;

    // Fetcher state encoding
    typedef logic [0:0] cgia_state_t;
    localparam cgia_state_t c_st_idle  = 1'b0;
    localparam cgia_state_t c_st_fetch = 1'b1;

endpackage : cgia_pkg
`default_nettype wire

// File: rtl/cgia_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : cgia_fetcher
// Description : CGIA video DMA engine. Non-pipelined Wishbone classic read
//               master fetching WORDS 16-bit words per scan line into one of
//               two line buffers. Triggered by HSYNC & DEN, pointer reloaded
//               from base_i on VSYNC.
// Revision    : 1.0 - initial release
// ============================================================================
module cgia_fetcher
    import cgia_pkg::*;
#(
    parameter int WORDS = 40,
    parameter int LB_AW = 6,
    parameter int ADR_W = c_adr_w
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               hsync_i,
    input  logic               den_i,
    input  logic               vsync_i,
    input  logic [ADR_W-1:0]   base_i,
    output logic               cyc_o,
    output logic               stb_o,
    output logic               we_o,
    output logic [ADR_W-1:0]   adr_o,
    input  logic [c_dat_w-1:0] dat_i,
    input  logic               ack_i,
    output logic               lb_we_o,
    output logic               lb_sel_o,
    output logic [LB_AW-1:0]   lb_adr_o,
    output logic [c_dat_w-1:0] lb_dat_o
);

    localparam logic [LB_AW-1:0] c_last_word = LB_AW'(WORDS - 1);

    cgia_state_t          r_state;
    cgia_state_t          w_state_nxt;
    logic [ADR_W-1:0]     r_ptr;
    logic [ADR_W-1:0]     w_ptr;
    logic                 r_rld;      // base_i reload owed, honoured only while idle
    logic                 r_armed;    // one fetch per HSYNC pulse
    logic                 r_cyc;
    logic [LB_AW-1:0]     r_cnt;
    logic                 r_lb_we;
    logic                 r_lb_sel;
    logic [LB_AW-1:0]     r_lb_adr;
    logic [c_dat_w-1:0]   r_lb_dat;
    logic                 w_start;
    logic                 w_last;

    // Effective pointer: a pending reload (reset or VSYNC) shows base_i while idle
    assign w_ptr   = (r_rld && (r_state == c_st_idle)) ? base_i : r_ptr;
    assign w_start = (r_state == c_st_idle) && hsync_i && den_i && r_armed;
    assign w_last  = (r_state == c_st_fetch) && ack_i && (r_cnt == c_last_word);

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: enter on a qualified HSYNC, leave after the last ack
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_start) w_state_nxt = c_st_fetch;
            c_st_fetch: if (w_last)  w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // Bus cycle, pointer, word counter and HSYNC arming
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cyc   <= 1'b0;
            r_ptr   <= '0;
            r_rld   <= 1'b1;
            r_armed <= 1'b1;
            r_cnt   <= '0;
        end else begin
            if (!hsync_i) begin
                r_armed <= 1'b1;
            end
            if (r_state == c_st_idle) begin
                if (w_start) begin
                    r_cyc   <= 1'b1;
                    r_ptr   <= w_ptr;
                    r_cnt   <= '0;
                    r_armed <= 1'b0;
                    r_rld   <= vsync_i;
                end else begin
                    if (r_rld) begin
                        r_ptr <= base_i;
                    end
                    r_rld <= vsync_i;
                end
            end else begin
                if (vsync_i) begin
                    r_rld <= 1'b1;
                end
                if (ack_i) begin
                    r_ptr <= r_ptr + ADR_W'(1);
                    r_cnt <= r_cnt + LB_AW'(1);
                    if (w_last) begin
                        r_cyc <= 1'b0;
                    end
                end
            end
        end
    end

    // Line-buffer write port: one-cycle pulse per acked word, ping-pong select
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_lb_we  <= 1'b0;
            r_lb_sel <= 1'b0;
            r_lb_adr <= '0;
            r_lb_dat <= '0;
        end else begin
            r_lb_we <= 1'b0;
            if (w_start) begin
                r_lb_sel <= ~r_lb_sel;
            end
            if ((r_state == c_st_fetch) && ack_i) begin
                r_lb_we  <= 1'b1;
                r_lb_adr <= r_cnt;
                r_lb_dat <= dat_i;
            end
        end
    end

    assign cyc_o    = r_cyc;
    assign stb_o    = r_cyc;
    assign we_o     = 1'b0;
    assign adr_o    = w_ptr;
    assign lb_we_o  = r_lb_we;
    assign lb_sel_o = r_lb_sel;
    assign lb_adr_o = r_lb_adr;
    assign lb_dat_o = r_lb_dat;

endmodule : cgia_fetcher
`default_nettype wire

// File: tb/tb_cgia_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_cgia_fetcher
// Description : Self-checking bench for cgia_fetcher with a Wishbone slave
//               model and a line-buffer write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cgia_fetcher;

    localparam int WORDS = 4;
    localparam int LB_AW = 6;
    localparam int ADR_W = 23;
    localparam logic [ADR_W-1:0] BASE = 23'h001000;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic              hsync_i, den_i, vsync_i;
    logic [ADR_W-1:0]  base_i;
    logic              cyc_o, stb_o, we_o;
    logic [ADR_W-1:0]  adr_o;
    logic [15:0]       dat_i;
    logic              ack_i;
    logic              lb_we_o, lb_sel_o;
    logic [LB_AW-1:0]  lb_adr_o;
    logic [15:0]       lb_dat_o;

    int total = 0;
    int bad   = 0;

    // Slave / scoreboard model state
    int                waits = 0;
    int                wcnt  = 0;
    int                idx   = 0;
    int                n_acks = 0;
    int                n_writes = 0;
    logic [ADR_W-1:0]  exp_ptr = BASE;
    logic              exp_sel = 1'b0;
    logic [LB_AW+15:0] q[$];

    cgia_fetcher #(.WORDS(WORDS), .LB_AW(LB_AW), .ADR_W(ADR_W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .hsync_i(hsync_i), .den_i(den_i),
        .vsync_i(vsync_i), .base_i(base_i), .cyc_o(cyc_o), .stb_o(stb_o),
        .we_o(we_o), .adr_o(adr_o), .dat_i(dat_i), .ack_i(ack_i),
        .lb_we_o(lb_we_o), .lb_sel_o(lb_sel_o), .lb_adr_o(lb_adr_o),
        .lb_dat_o(lb_dat_o)
    );

    always #5 clk_i = ~clk_i;

    // Wishbone slave: returns adr_o[15:0] after 'waits' wait states, pushes expectation
    always @(negedge clk_i) begin
        if (reset_i || !(cyc_o && stb_o)) begin
            ack_i = 1'b0;
            wcnt  = 0;
            idx   = 0;
        end else begin
            total++;
            if (adr_o !== exp_ptr) begin
                bad++;
                $display("FAIL adr_stable: adr_o=%h expected=%h", adr_o, exp_ptr);
            end
            if (wcnt == waits) begin
                ack_i = 1'b1;
                dat_i = adr_o[15:0];
                q.push_back({LB_AW'(idx), exp_ptr[15:0]});
                exp_ptr = exp_ptr + 1'b1;
                idx++;
                n_acks++;
                wcnt = 0;
            end else begin
                ack_i = 1'b0;
                wcnt++;
            end
        end
    end

    // Line-buffer monitor: pops and compares each write
    always @(negedge clk_i) begin
        if (!reset_i && lb_we_o) begin
            logic [LB_AW+15:0] e;
            n_writes++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL lb_unexpected: adr=%0d dat=%h required=no write", lb_adr_o, lb_dat_o);
            end else begin
                e = q.pop_front();
                if ({lb_adr_o, lb_dat_o} !== e || lb_sel_o !== exp_sel) begin
                    bad++;
                    $display("FAIL lb_write: adr=%0d dat=%h sel=%b required adr=%0d dat=%h sel=%b",
                             lb_adr_o, lb_dat_o, lb_sel_o, e[LB_AW+15:16], e[15:0], exp_sel);
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (cyc_o === 1'b1 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        total++;
        if (cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL %s_timeout: cyc_o=%b required=0", name, cyc_o);
        end
        @(negedge clk_i);
        #1;
    endtask

    task automatic start_line(input string name);
        hsync_i = 1'b1; den_i = 1'b1;
        exp_sel = ~exp_sel;
        @(negedge clk_i); #1;
        total++;
        if (cyc_o !== 1'b1 || stb_o !== 1'b1 || lb_sel_o !== exp_sel) begin
            bad++;
            $display("FAIL %s_start: cyc=%b stb=%b sel=%b required 1 1 %b", name, cyc_o, stb_o, lb_sel_o, exp_sel);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1; hsync_i = 0; den_i = 0; vsync_i = 0; ack_i = 0; dat_i = '0; base_i = BASE;
        @(negedge clk_i); #1;
        total++;
        if (cyc_o !== 0 || stb_o !== 0 || we_o !== 0 || lb_we_o !== 0 || lb_sel_o !== 0 ||
            lb_adr_o !== '0 || lb_dat_o !== '0 || adr_o !== BASE) begin
            bad++;
            $display("FAIL reset_state: cyc=%b stb=%b we=%b lbwe=%b sel=%b adr=%h required 0 0 0 0 0 %h",
                     cyc_o, stb_o, we_o, lb_we_o, lb_sel_o, adr_o, BASE);
        end
        reset_i = 1'b0;
        @(negedge clk_i); #1;
        total++;
        if (cyc_o !== 0 || lb_we_o !== 0) begin
            bad++;
            $display("FAIL reset_release: cyc=%b lbwe=%b required 0 0", cyc_o, lb_we_o);
        end
    endtask

    task automatic test_vsync_fetch();
        base_i = BASE;
        vsync_i = 1'b1;
        @(negedge clk_i);
        vsync_i = 1'b0;
        exp_ptr = BASE;
        @(negedge clk_i); #1;
        total++;
        if (adr_o !== BASE) begin
            bad++;
            $display("FAIL vsync_reload: adr_o=%h required=%h", adr_o, BASE);
        end
        n_acks = 0; n_writes = 0;
        start_line("vsync");
        hsync_i = 1'b0;
        wait_idle("vsync");
        total++;
        if (n_acks != WORDS || n_writes != WORDS || lb_sel_o !== 1'b1 || adr_o !== BASE + WORDS) begin
            bad++;
            $display("FAIL vsync_line: acks=%0d writes=%0d sel=%b adr=%h required %0d %0d 1 %h",
                     n_acks, n_writes, lb_sel_o, adr_o, WORDS, WORDS, BASE + WORDS);
        end
    endtask

    task automatic test_den_gate();
        hsync_i = 1'b1; den_i = 1'b0;
        @(negedge clk_i); #1;
        total++;
        if (cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL den_gate: cyc_o=%b required=0", cyc_o);
        end
        n_acks = 0; n_writes = 0;
        start_line("den");
        hsync_i = 1'b0;
        wait_idle("den");
        total++;
        if (n_acks != WORDS || n_writes != WORDS) begin
            bad++;
            $display("FAIL den_line: acks=%0d writes=%0d required %0d", n_acks, n_writes, WORDS);
        end
    endtask

    task automatic test_wait_states();
        logic [ADR_W-1:0] first;
        waits = 2;
        first = exp_ptr;
        n_acks = 0; n_writes = 0;
        start_line("wait");
        total++;
        if (adr_o !== BASE + 2*WORDS || first !== BASE + 2*WORDS) begin
            bad++;
            $display("FAIL wait_first_adr: adr_o=%h required=%h", adr_o, BASE + 2*WORDS);
        end
        hsync_i = 1'b0; den_i = 1'b0;
        wait_idle("wait");
        total++;
        if (n_acks != WORDS || n_writes != WORDS) begin
            bad++;
            $display("FAIL wait_line: acks=%0d writes=%0d required %0d", n_acks, n_writes, WORDS);
        end
        waits = 0;
    endtask

    task automatic test_hold_hsync();
        n_writes = 0;
        start_line("hold");
        wait_idle("hold");
        repeat (5) @(negedge clk_i);
        #1;
        total++;
        if (cyc_o !== 1'b0) begin
            bad++;
            $display("FAIL hold_retrigger: cyc_o=%b required=0", cyc_o);
        end
        hsync_i = 1'b0;
        @(negedge clk_i);
        start_line("rearm");
        hsync_i = 1'b0;
        wait_idle("rearm");
        total++;
        if (n_writes != 2*WORDS) begin
            bad++;
            $display("FAIL hold_writes: writes=%0d required=%0d", n_writes, 2*WORDS);
        end
    endtask

    task automatic test_reset_mid_fetch();
        start_line("midrst");
        hsync_i = 1'b0;
        @(negedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
        total++;
        if (cyc_o !== 1'b0 || stb_o !== 1'b0 || lb_sel_o !== 1'b0 || adr_o !== BASE) begin
            bad++;
            $display("FAIL midrst_async: cyc=%b stb=%b sel=%b adr=%h required 0 0 0 %h",
                     cyc_o, stb_o, lb_sel_o, adr_o, BASE);
        end
        q.delete();
        exp_ptr = BASE;
        exp_sel = 1'b0;
        @(negedge clk_i);
        #2;
        reset_i = 1'b0;
        @(negedge clk_i);
        n_acks = 0; n_writes = 0;
        start_line("after_rst");
        total++;
        if (adr_o !== BASE) begin
            bad++;
            $display("FAIL after_rst_adr: adr_o=%h required=%h", adr_o, BASE);
        end
        hsync_i = 1'b0;
        wait_idle("after_rst");
        total++;
        if (n_writes != WORDS || q.size() != 0) begin
            bad++;
            $display("FAIL after_rst_line: writes=%0d left=%0d required %0d 0", n_writes, q.size(), WORDS);
        end
    endtask

    initial begin
        test_reset();
        test_vsync_fetch();
        test_den_gate();
        test_wait_states();
        test_hold_hsync();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cgia_fetcher
`default_nettype wire
